spi_cntrl: RTL and testbench
============================

# spi_cntrl

Synthesizable SPI main controller (mode 0, MSB first, 8-bit frames) that drives chip select, serial clock and MOSI into an SPI subunit, and shifts back the subunit's MISO byte. It sits between a byte-level request interface in user logic and the off-chip (or simulation-model) subunit. Consecutive bytes can share one chip-select assertion via `hold_cs`, so multi-byte register accesses need no CS gaps.

## Interface
- `CLK_FREQUENCY`, 100_000_000, system clock frequency in Hz
- `SCLK_FREQUENCY`, 500_000, SPI serial clock frequency in Hz; H = CLK_FREQUENCY/(2*SCLK_FREQUENCY) clocks per SCLK half-period, integer, H >= 2 (elaboration error otherwise)

- `clk`  in  1  system clock; one clock domain, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  request a byte transfer; accepted in IDLE or HOLD only
- `data_to_send`  in  8  byte to transmit; sampled on the accepting cycle
- `hold_cs`  in  1  keep CS low after this byte; sampled on the accepting cycle, re-read live in HOLD
- `data_received`  out  8  last byte captured from MISO; valid from `done`, held until next `done`
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse when a byte completes
- `SPI_SCLK`  out  1  serial clock, idles low
- `SPI_MOSI`  out  1  serial data out
- `SPI_MISO`  in  1  serial data in; may be Z while CS high (never sampled then)
- `SPI_CS`  out  1  active-low chip select

## Operation
- All outputs registered. Reset values: `SPI_CS`=1, `SPI_SCLK`=0, `SPI_MOSI`=0, `busy`=0, `done`=0, `data_received`=8'h00; state IDLE, counters 0.
- States: IDLE, LOW, HIGH, HOLD, CS_END.
- IDLE: CS=1, SCLK=0. `start`=1 -> load shift register with `data_to_send`, latch `hold_cs`, bit count=0, CS=0, MOSI=bit7, go LOW.
- LOW: SCLK=0 for H cycles. On last cycle: sample `SPI_MISO` into receive shift register (same edge that raises SCLK, so value precedes subunit's posedge update), SCLK=1, go HIGH.
- HIGH: SCLK=1 for H cycles. On last cycle: SCLK=0, bit count+1, shift transmit register left, MOSI=next bit. If count was 7 (8th bit): `data_received`<=receive register, `done`=1 for that one cycle; go HOLD if latched hold_cs=1, else CS_END. Otherwise go LOW.
- HOLD: CS=0, SCLK=0, MOSI holds last driven value. `start`=1 -> load/latch as in IDLE (CS stays 0), go LOW. Else `hold_cs`=0 -> CS=1, go CS_END. Else stay.
- CS_END: CS=1 for H cycles (minimum deselect time), then IDLE. `start` ignored here.
- `start` in LOW/HIGH/CS_END is ignored, not queued; `data_to_send`/`hold_cs` changes mid-byte have no effect.
- `rst` asserted in any state: next cycle all outputs at reset values (CS=1 immediately, SCLK=0), no `done`, partial byte discarded.

## Timing
- Byte: 8 LOW + 8 HIGH phases = 16H clocks. If `start` accepted at edge 0, CS falls at edge 0 output, first SCLK rise at edge H, `done` high for the cycle after edge 16H.
- SCLK period exactly 2H clocks, 50% duty; SCLK never toggles while CS=1.
- MOSI changes only with SCLK falling (or CS falling for bit 7): setup to rising edge = H clocks.
- Back-to-back held bytes: `start` in the `done`+1 cycle (HOLD) gives next SCLK rise H+1 clocks later; no CS pulse.
- Unheld byte: CS rises on the `done` edge+1, `busy` drops H+1 cycles after `done`.

## Test plan
- Reset: hold `rst` 5 cycles mid-idle -> CS=1, SCLK=0, MOSI=0, busy=0, done=0, data_received=00.
- Single byte (H=5): send 8'hA5, subunit model returns 8'h3C -> MOSI sequence 1,0,1,0,0,1,0,1 sampled at SCLK rises, `done` 80 cycles after accept, data_received=3C, exactly 8 SCLK rises, CS low for whole byte then high.
- Held pair: 8'h12 with hold_cs=1, then 8'h34 with hold_cs=0 issued in HOLD -> CS never rises between bytes, two `done` pulses, subunit reports 0x12 and 0x34, CS high after second.
- HOLD release: hold_cs=1 byte, then drop hold_cs with no start -> CS rises next cycle, busy low H cycles later, no SCLK edges.
- Ignored start: pulse `start` with 8'hFF at bit 3 of an 8'h00 transfer -> MOSI stays 0 all 8 bits, one `done` only.
- Reset mid-byte: assert `rst` after 4 SCLK rises -> CS=1 and SCLK=0 next cycle, no `done`, data_received unchanged from reset value.

Source files
------------

// File: rtl/spi_cntrl_if.sv
// Byte-level request bus between user logic and spi_cntrl.
//   start         : request a byte transfer
//   data_to_send  : byte to transmit, sampled on the accepting cycle
//   hold_cs       : keep chip select low after this byte
//   data_received : last byte shifted in from MISO
//   busy          : controller is not idle
//   done          : one-cycle pulse when a byte completes
// master = user logic issuing requests, slave = the controller.
interface spi_cntrl_if;
  logic       start;
  logic [7:0] data_to_send;
  logic       hold_cs;
  logic [7:0] data_received;
  logic       busy;
  logic       done;

  modport master (
    output start, data_to_send, hold_cs,
    input  data_received, busy, done
  );

  modport slave (
    input  start, data_to_send, hold_cs,
    output data_received, busy, done
  );
endinterface

// File: rtl/spi_cntrl.sv
// SPI main controller: mode 0, MSB first, 8-bit frames.
//   clk, rst  : system clock, synchronous active-high reset
//   bus       : byte request bus (slave side of spi_cntrl_if)
//   SPI_SCLK  : serial clock, idles low, period 2*H system clocks
//   SPI_MOSI  : serial data out, changes with SCLK falling / CS falling
//   SPI_MISO  : serial data in, sampled on the clock edge that raises SCLK
//   SPI_CS    : active-low chip select; may stay low across bytes (hold_cs)
// All outputs are registered.
module spi_cntrl #(
  parameter int unsigned CLK_FREQUENCY  = 100_000_000,
  parameter int unsigned SCLK_FREQUENCY = 500_000
) (
  input  logic       clk,
  input  logic       rst,
  spi_cntrl_if.slave bus,
  output logic       SPI_SCLK,
  output logic       SPI_MOSI,
  input  logic       SPI_MISO,
  output logic       SPI_CS
);

  localparam int unsigned H  = CLK_FREQUENCY / (2 * SCLK_FREQUENCY);
  localparam int unsigned CW = $clog2(H + 1);

  generate
    if (H < 2 || (CLK_FREQUENCY % (2 * SCLK_FREQUENCY)) != 0) begin : g_bad_ratio
      $error("spi_cntrl: CLK_FREQUENCY/(2*SCLK_FREQUENCY) must be an integer >= 2");
    end
  endgenerate

  typedef enum logic [2:0] {IDLE, LOW, HIGH, HOLD, CS_END} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      tx_q, tx_d;
  logic [7:0]      rx_q, rx_d;
  logic [7:0]      rxout_q, rxout_d;
  logic            hold_q, hold_d;
  logic            sclk_q, sclk_d;
  logic            mosi_q, mosi_d;
  logic            cs_q, cs_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;

  logic            phase_last;
  assign phase_last = (cnt_q == CW'(H - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      rxout_q <= '0;
      hold_q  <= 1'b0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      cs_q    <= 1'b1;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rxout_q <= rxout_d;
      hold_q  <= hold_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      cs_q    <= cs_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    rxout_d = rxout_q;
    hold_d  = hold_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    cs_d    = cs_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        cs_d   = 1'b1;
        sclk_d = 1'b0;
        if (bus.start) begin
          tx_d    = bus.data_to_send;
          hold_d  = bus.hold_cs;
          bit_d   = '0;
          cnt_d   = '0;
          cs_d    = 1'b0;
          mosi_d  = bus.data_to_send[7];
          state_d = LOW;
        end
      end
      LOW: begin
        if (phase_last) begin
          rx_d    = {rx_q[6:0], SPI_MISO};
          sclk_d  = 1'b1;
          cnt_d   = '0;
          state_d = HIGH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HIGH: begin
        if (phase_last) begin
          sclk_d = 1'b0;
          cnt_d  = '0;
          bit_d  = bit_q + 3'd1;
          tx_d   = {tx_q[6:0], 1'b0};
          mosi_d = tx_q[6];
          if (bit_q == 3'd7) begin
            rxout_d = rx_q;
            done_d  = 1'b1;
            state_d = hold_q ? HOLD : CS_END;
          end else begin
            state_d = LOW;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        cs_d   = 1'b0;
        sclk_d = 1'b0;
        if (bus.start) begin
          tx_d    = bus.data_to_send;
          hold_d  = bus.hold_cs;
          bit_d   = '0;
          cnt_d   = '0;
          mosi_d  = bus.data_to_send[7];
          state_d = LOW;
        end else if (!bus.hold_cs) begin
          // CS already rises on this edge, so the deselect count starts at 1
          // to keep CS high for exactly H cycles before IDLE.
          cs_d    = 1'b1;
          cnt_d   = CW'(1);
          state_d = CS_END;
        end
      end
      CS_END: begin
        // Entered from HIGH with count 0: CS rises one cycle after done.
        cs_d = 1'b1;
        if (cnt_q == CW'(H)) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  assign SPI_SCLK          = sclk_q;
  assign SPI_MOSI          = mosi_q;
  assign SPI_CS            = cs_q;
  assign bus.data_received = rxout_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;

endmodule

// File: tb/tb_spi_cntrl.sv
module tb_spi_cntrl;
  localparam int unsigned CLKF  = 100_000_000;
  localparam int unsigned SCLKF = 10_000_000;
  localparam int          H     = 5;
  localparam int          BYTE_CYC = 16 * H;

  logic clk = 1'b0;
  logic rst;
  logic sclk, mosi, miso, cs;

  always #5 clk = ~clk;

  spi_cntrl_if bus ();

  spi_cntrl #(.CLK_FREQUENCY(CLKF), .SCLK_FREQUENCY(SCLKF)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .SPI_SCLK (sclk),
    .SPI_MOSI (mosi),
    .SPI_MISO (miso),
    .SPI_CS   (cs)
  );

  int tests = 0;
  int fails = 0;

  // ---------------- SPI subunit model (mode 0) ----------------
  logic [7:0] resp [0:63];
  int         resp_n = 0;
  int         resp_rd = 0;
  logic [7:0] got [0:63];
  int         got_n = 0;
  int         rises = 0;
  int         cs_rises = 0;
  int         viol = 0;
  int         nbit = 0;
  logic [7:0] sh = 8'h00;
  logic [7:0] rcv = 8'h00;
  logic       prev_cs = 1'b1;
  logic       prev_sclk = 1'b0;
  logic       fresh = 1'b0;
  logic       popped = 1'b0;

  assign miso = sh[7];

  always @(cs or sclk) begin
    if (prev_cs && cs === 1'b0 && !fresh) begin
      nbit = 0;
      popped = (resp_rd < resp_n);
      sh = popped ? resp[resp_rd % 64] : 8'h00;
      if (popped) resp_rd++;
      fresh = 1'b1;
    end
    if (!prev_sclk && sclk === 1'b1) begin
      if (cs !== 1'b0) viol++;
      else begin
        fresh = 1'b0;
        rises++;
        rcv = {rcv[6:0], mosi};
        nbit++;
        if (nbit == 8) begin
          got[got_n % 64] = rcv;
          got_n++;
          nbit = 0;
        end
      end
    end
    if (prev_sclk && sclk === 1'b0 && cs === 1'b0) begin
      if (nbit == 0) begin
        popped = (resp_rd < resp_n);
        sh = popped ? resp[resp_rd % 64] : 8'h00;
        if (popped) resp_rd++;
        fresh = 1'b1;
      end else begin
        sh = {sh[6:0], 1'b0};
      end
    end
    if (!prev_cs && cs === 1'b1) begin
      cs_rises++;
      // a byte preloaded at the end of the previous frame was never shifted
      if (fresh && popped) resp_rd--;
      fresh = 1'b0;
    end
    prev_cs   = (cs !== 1'b0);
    prev_sclk = (sclk === 1'b1);
  end

  int done_cnt = 0;
  always @(posedge clk) if (bus.done === 1'b1) done_cnt++;

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_resp(input logic [7:0] r);
    resp[resp_n % 64] = r;
    resp_n++;
  endtask

  task automatic send(input logic [7:0] d, input logic h);
    bus.start = 1'b1;
    bus.data_to_send = d;
    bus.hold_cs = h;
    tick();
    bus.start = 1'b0;
    bus.data_to_send = 8'($urandom);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (bus.done !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_rises(input int target);
    int n = 0;
    while (rises < target && n < 400) begin
      tick();
      n++;
    end
    tests++;
    if (rises < target) begin
      fails++;
      $display("FAIL wait_rises: got %0d rises expected %0d", rises, target);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    repeat (5) tick();
    tests++; if (cs !== 1'b1) begin fails++; $display("FAIL reset_cs: got %b expected 1", cs); end
    tests++; if (sclk !== 1'b0) begin fails++; $display("FAIL reset_sclk: got %b expected 0", sclk); end
    tests++; if (mosi !== 1'b0) begin fails++; $display("FAIL reset_mosi: got %b expected 0", mosi); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    tests++; if (bus.data_received !== 8'h00) begin fails++; $display("FAIL reset_rx: got %h expected 00", bus.data_received); end
    rst = 1'b0;
    tick();
  endtask

  task automatic one_byte(input logic [7:0] d, input logic [7:0] r);
    int n, m, r0, g0, c0, d0, v0;
    r0 = rises; g0 = got_n; c0 = cs_rises; d0 = done_cnt; v0 = viol;
    push_resp(r);
    send(d, 1'b0);
    tests++; if (cs !== 1'b0) begin fails++; $display("FAIL byte_cs_fall: got %b expected 0", cs); end
    tests++; if (mosi !== d[7]) begin fails++; $display("FAIL byte_mosi7: got %b expected %b", mosi, d[7]); end
    wait_done(n);
    tests++; if (n != BYTE_CYC) begin fails++; $display("FAIL byte_latency: got %0d expected %0d", n, BYTE_CYC); end
    tests++; if (bus.data_received !== r) begin fails++; $display("FAIL byte_rx: got %h expected %h", bus.data_received, r); end
    tests++; if (rises - r0 != 8) begin fails++; $display("FAIL byte_rises: got %0d expected 8", rises - r0); end
    tests++; if (got_n != g0 + 1 || got[(got_n - 1) % 64] !== d) begin
      fails++; $display("FAIL byte_mosi_seq: got %h expected %h", got[(got_n - 1) % 64], d);
    end
    tests++; if (cs_rises != c0 || cs !== 1'b0) begin fails++; $display("FAIL byte_cs_held: got rises %0d cs %b expected 0/0", cs_rises - c0, cs); end
    tick();
    tests++; if (cs !== 1'b1 || bus.done !== 1'b0) begin fails++; $display("FAIL byte_after_done: got cs %b done %b expected 1/0", cs, bus.done); end
    m = 1;
    while (bus.busy === 1'b1 && m < 50) begin tick(); m++; end
    tests++; if (m != H + 1) begin fails++; $display("FAIL byte_busy_drop: got %0d expected %0d", m, H + 1); end
    tests++; if (done_cnt - d0 != 1 || viol != v0) begin fails++; $display("FAIL byte_pulses: got done %0d viol %0d expected 1/0", done_cnt - d0, viol - v0); end
    tests++; if (bus.data_received !== r) begin fails++; $display("FAIL byte_rx_held: got %h expected %h", bus.data_received, r); end
  endtask

  task automatic test_single_byte();
    one_byte(8'hA5, 8'h3C);
    for (int i = 0; i < 4; i++) one_byte(8'($urandom), 8'($urandom));
  endtask

  task automatic held_chain(input int k);
    logic [7:0] d [0:7];
    logic [7:0] r [0:7];
    int n, n2, c0, d0, g0;
    for (int i = 0; i < k; i++) begin
      d[i] = (k == 2) ? ((i == 0) ? 8'h12 : 8'h34) : 8'($urandom);
      r[i] = 8'($urandom);
      push_resp(r[i]);
    end
    c0 = cs_rises; d0 = done_cnt; g0 = got_n;
    for (int i = 0; i < k; i++) begin
      send(d[i], (i < k - 1));
      n = 0;
      while (sclk !== 1'b1 && n < 50) begin tick(); n++; end
      tests++; if (n != H) begin fails++; $display("FAIL held_first_rise: got %0d expected %0d", n, H); end
      wait_done(n2);
      tests++; if (n + n2 != BYTE_CYC) begin fails++; $display("FAIL held_latency: got %0d expected %0d", n + n2, BYTE_CYC); end
      tests++; if (bus.data_received !== r[i]) begin fails++; $display("FAIL held_rx: got %h expected %h", bus.data_received, r[i]); end
      tests++; if (got[(got_n - 1) % 64] !== d[i]) begin fails++; $display("FAIL held_mosi: got %h expected %h", got[(got_n - 1) % 64], d[i]); end
    end
    tests++; if (cs_rises != c0) begin fails++; $display("FAIL held_no_cs_gap: got %0d expected 0", cs_rises - c0); end
    tests++; if (got_n - g0 != k) begin fails++; $display("FAIL held_bytes: got %0d expected %0d", got_n - g0, k); end
    tick();
    tests++; if (cs !== 1'b1) begin fails++; $display("FAIL held_cs_end: got %b expected 1", cs); end
    repeat (H + 2) tick();
    tests++; if (done_cnt - d0 != k || bus.busy !== 1'b0) begin
      fails++; $display("FAIL held_done_count: got %0d busy %b expected %0d/0", done_cnt - d0, bus.busy, k);
    end
  endtask

  task automatic test_back_to_back();
    held_chain(2);
    held_chain(3);
  endtask

  task automatic test_hold_release();
    int n, m, r0;
    logic [7:0] r;
    r = 8'($urandom);
    push_resp(r);
    r0 = rises;
    send(8'($urandom), 1'b1);
    wait_done(n);
    tests++; if (bus.data_received !== r) begin fails++; $display("FAIL hold_rx: got %h expected %h", bus.data_received, r); end
    repeat (3) tick();
    tests++; if (cs !== 1'b0 || bus.busy !== 1'b1) begin fails++; $display("FAIL hold_state: got cs %b busy %b expected 0/1", cs, bus.busy); end
    bus.hold_cs = 1'b0;
    tick();
    tests++; if (cs !== 1'b1) begin fails++; $display("FAIL hold_release_cs: got %b expected 1", cs); end
    m = 0;
    while (bus.busy === 1'b1 && m < 50) begin tick(); m++; end
    tests++; if (m != H) begin fails++; $display("FAIL hold_release_busy: got %0d expected %0d", m, H); end
    tests++; if (rises - r0 != 8) begin fails++; $display("FAIL hold_release_sclk: got %0d expected 8", rises - r0); end
  endtask

  task automatic test_ignored_start();
    int n, r0, d0, g0;
    r0 = rises; d0 = done_cnt; g0 = got_n;
    push_resp(8'($urandom));
    send(8'h00, 1'b0);
    wait_rises(r0 + 3);
    repeat (H) tick();
    bus.start = 1'b1;
    bus.data_to_send = 8'hFF;
    bus.hold_cs = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.hold_cs = 1'b0;
    wait_done(n);
    tests++; if (got[(got_n - 1) % 64] !== 8'h00 || got_n - g0 != 1) begin
      fails++; $display("FAIL ignored_mosi: got %h expected 00", got[(got_n - 1) % 64]);
    end
    repeat (100) tick();
    tests++; if (done_cnt - d0 != 1) begin fails++; $display("FAIL ignored_done_count: got %0d expected 1", done_cnt - d0); end
    tests++; if (rises - r0 != 8 || bus.busy !== 1'b0) begin fails++; $display("FAIL ignored_rises: got %0d busy %b expected 8/0", rises - r0, bus.busy); end
  endtask

  task automatic test_reset_mid();
    int r0, d0;
    r0 = rises; d0 = done_cnt;
    push_resp(8'($urandom));
    send(8'($urandom), 1'b0);
    wait_rises(r0 + 4);
    rst = 1'b1;
    tick();
    tests++; if (cs !== 1'b1 || sclk !== 1'b0) begin fails++; $display("FAIL rstmid_pins: got cs %b sclk %b expected 1/0", cs, sclk); end
    tests++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin fails++; $display("FAIL rstmid_flags: got busy %b done %b expected 0/0", bus.busy, bus.done); end
    tests++; if (bus.data_received !== 8'h00) begin fails++; $display("FAIL rstmid_rx: got %h expected 00", bus.data_received); end
    rst = 1'b0;
    repeat (100) tick();
    tests++; if (done_cnt != d0 || cs !== 1'b1) begin fails++; $display("FAIL rstmid_no_done: got %0d cs %b expected 0/1", done_cnt - d0, cs); end
    one_byte(8'($urandom), 8'($urandom));
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.data_to_send = 8'h00;
    bus.hold_cs = 1'b0;
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_hold_release();
    test_ignored_start();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
